// File: rtl/mem_line_fetch_pkg.sv
// Shared types and sizing for the cache-line fetch unit.
// Holds line geometry, the cache-line number type and the FSM state enum.
package mem_line_fetch_pkg;

  localparam int MCN_W  = 58;
  localparam int BEATS  = 8;
  localparam int BEAT_W = 64;

  typedef logic [MCN_W-1:0] mcn_t;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

endpackage

// File: rtl/mem_line_fetch_line_asm.sv
// Line assembly register: beat-indexed 64-bit writes into one line.
// Ports: clk_i, rst_i, clear_i (zero line), wr_i/idx_i/data_i (beat write), line_o.
module line_asm #(
  parameter int BEATS  = 8,
  parameter int BEAT_W = 64,
  parameter int IDX_W  = $clog2(BEATS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    wr_i,
  input  logic [IDX_W-1:0]        idx_i,
  input  logic [BEAT_W-1:0]       data_i,
  output logic [BEATS*BEAT_W-1:0] line_o
);

  logic [BEATS*BEAT_W-1:0] line_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_q <= '0;
    end else if (clear_i) begin
      line_q <= '0;
    end else if (wr_i) begin
      line_q[idx_i*BEAT_W +: BEAT_W] <= data_i;
    end
  end

  assign line_o = line_q;

endmodule

// File: rtl/mem_line_fetch.sv
// Fetches one cache line as a fixed 8-beat bus burst for the walker.
// Ports: walker req/resp handshakes, bus AR channel, bus R channel.
module mem_line_fetch #(
  parameter int MCN_W = mem_line_fetch_pkg::MCN_W,
  parameter int BEATS = mem_line_fetch_pkg::BEATS
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req_i_ready,
  input  logic              mem_req_i_valid,
  input  logic [MCN_W-1:0]  mem_req_i_bits_mcn,
  input  logic              mem_resp_o_ready,
  output logic              mem_resp_o_valid,
  output logic [BEATS*64-1:0] mem_resp_o_bits_data,
  output logic              mem_resp_o_bits_err,
  input  logic              bus_ar_ready,
  output logic              bus_ar_valid,
  output logic [63:0]       bus_ar_addr,
  output logic [2:0]        bus_ar_len,
  output logic              bus_r_ready,
  input  logic              bus_r_valid,
  input  logic [63:0]       bus_r_data,
  input  logic              bus_r_last,
  input  logic              bus_r_err
);

  import mem_line_fetch_pkg::*;

  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS-1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [MCN_W-1:0] mcn_q, mcn_d;
  logic             line_clr;
  logic             line_wr;
  logic             last_beat;

  assign last_beat = (cnt_q == LAST_IDX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      mcn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mcn_q   <= mcn_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    mcn_d    = mcn_q;
    line_clr = 1'b0;
    line_wr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_req_i_valid && !reset) begin
          mcn_d    = mem_req_i_bits_mcn;
          err_d    = 1'b0;
          line_clr = 1'b1;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (bus_ar_ready) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus_r_valid) begin
          line_wr = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          // last must mark exactly the final beat
          if (bus_r_err || (bus_r_last != last_beat)) begin
            err_d = 1'b1;
          end
          // beat count, not bus_r_last, ends the burst
          if (last_beat) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (mem_resp_o_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  line_asm #(
    .BEATS  (BEATS),
    .BEAT_W (64),
    .IDX_W  (CNT_W)
  ) u_line_asm (
    .clk_i   (clock),
    .rst_i   (reset),
    .clear_i (line_clr),
    .wr_i    (line_wr),
    .idx_i   (cnt_q),
    .data_i  (bus_r_data),
    .line_o  (mem_resp_o_bits_data)
  );

  // ready is masked while reset is held
  assign mem_req_i_ready     = (state_q == IDLE) && !reset;
  assign bus_ar_valid        = (state_q == ADDR);
  assign bus_ar_addr         = 64'({mcn_q, 6'b0});
  assign bus_ar_len          = 3'(BEATS-1);
  assign bus_r_ready         = (state_q == DATA);
  assign mem_resp_o_valid    = (state_q == RESP);
  assign mem_resp_o_bits_err = err_q;

endmodule
